// File: rtl/sr_cmd_gen.sv
// Command front-end for an S/R flip-flop: synchronizes and debounces set/clear requests, then arbitrates one-cycle s/r pulses.
// Optional `SR_CMD_SET_PRIORITY_EN: set wins a simultaneous request instead of both being dropped.
module sr_cmd_gen #(
   parameter int DB_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic set_req,
   input  logic clr_req,
   output logic s,
   output logic r,
   output logic conflict
);

   typedef enum logic [1:0] {IDLE, PULSE_S, PULSE_R, GAP} state_t;

   localparam logic [7:0] CNT_LAST = 8'(DB_CYCLES - 1);

   // Bit 0 is the set channel, bit 1 the clear channel.
   logic [1:0] sync1_q, sync2_q;
   logic [1:0] deb_q, deb_d;
   logic [1:0] deb_prev_q;
   logic [7:0] cnt_q [2];
   logic [7:0] cnt_d [2];
   logic [1:0] rise;
   logic       set_pend_q, set_pend_d;
   logic       clr_pend_q, clr_pend_d;
   logic       set_take, clr_take;
   state_t     state_q, state_d;
   logic       s_q, s_d, r_q, r_d, conflict_q, conflict_d;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      deb_d = deb_q;
      for (int i = 0; i < 2; i++) begin
         cnt_d[i] = 8'd0;
         if (sync2_q[i] != deb_q[i]) begin
            if (cnt_q[i] == CNT_LAST) deb_d[i] = ~deb_q[i];
            else                      cnt_d[i] = cnt_q[i] + 8'd1;
         end
      end
      rise = deb_q & ~deb_prev_q;
   end

   always_comb begin
      state_d    = state_q;
      set_take   = 1'b0;
      clr_take   = 1'b0;
      conflict_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (set_pend_q && clr_pend_q) begin
               set_take   = 1'b1;
               clr_take   = 1'b1;
               conflict_d = 1'b1;
`ifdef SR_CMD_SET_PRIORITY_EN
               state_d    = PULSE_S;
`else
               state_d    = IDLE;
`endif
            end else if (set_pend_q) begin
               set_take = 1'b1;
               state_d  = PULSE_S;
            end else if (clr_pend_q) begin
               clr_take = 1'b1;
               state_d  = PULSE_R;
            end
         end
         PULSE_S, PULSE_R: state_d = GAP;
         GAP:              state_d = IDLE;
         default:          state_d = IDLE;
      endcase
      // A fresh event on the serving edge is a new command and stays pending.
      set_pend_d = rise[0] | (set_pend_q & ~set_take);
      clr_pend_d = rise[1] | (clr_pend_q & ~clr_take);
      s_d        = (state_d == PULSE_S);
      r_d        = (state_d == PULSE_R);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         deb_q      <= '0;
         deb_prev_q <= '0;
         for (int i = 0; i < 2; i++) cnt_q[i] <= 8'd0;
         set_pend_q <= 1'b0;
         clr_pend_q <= 1'b0;
         state_q    <= IDLE;
         s_q        <= 1'b0;
         r_q        <= 1'b0;
         conflict_q <= 1'b0;
      end else begin
         sync1_q    <= {clr_req, set_req};
         sync2_q    <= sync1_q;
         deb_q      <= deb_d;
         deb_prev_q <= deb_q;
         for (int i = 0; i < 2; i++) cnt_q[i] <= cnt_d[i];
         set_pend_q <= set_pend_d;
         clr_pend_q <= clr_pend_d;
         state_q    <= state_d;
         s_q        <= s_d;
         r_q        <= r_d;
         conflict_q <= conflict_d;
      end
   end

   assign s        = s_q;
   assign r        = r_q;
   assign conflict = conflict_q;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Directed self-checking bench for sr_cmd_gen (DB_CYCLES=4); edge numbers count from the first edge that samples new stimulus.
`timescale 1ns/1ps
module tb_sr_cmd_gen;

   logic clk = 1'b0;
   logic reset;
   logic set_req, clr_req;
   logic s, r, conflict;

   int checks = 0;
   int errors = 0;

   int edge_n;
   int s_cnt, r_cnt, c_cnt, overlap;
   int s_first, r_first, c_first;

   sr_cmd_gen #(.DB_CYCLES(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .set_req  (set_req),
      .clr_req  (clr_req),
      .s        (s),
      .r        (r),
      .conflict (conflict)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   task automatic clear_stats();
      edge_n  = 0;
      s_cnt   = 0; r_cnt   = 0; c_cnt   = 0; overlap = 0;
      s_first = -1; r_first = -1; c_first = -1;
   endtask

   // Advance n edges, sampling outputs 1 ns after each rising edge.
   task automatic run(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         edge_n++;
         if (s) begin s_cnt++; if (s_first < 0) s_first = edge_n; end
         if (r) begin r_cnt++; if (r_first < 0) r_first = edge_n; end
         if (conflict) begin c_cnt++; if (c_first < 0) c_first = edge_n; end
         if (s && r) overlap++;
      end
   endtask

   task automatic do_reset();
      set_req = 1'b0;
      clr_req = 1'b0;
      reset   = 1'b1;
      run(3);
      reset   = 1'b0;
      run(2);
      clear_stats();
   endtask

   initial begin
      set_req = 1'b0;
      clr_req = 1'b0;
      reset   = 1'b1;
      clear_stats();
      #12;
      check("reset_s", int'(s), 0);
      check("reset_r", int'(r), 0);
      check("reset_conflict", int'(conflict), 0);
      run(2);
      reset = 1'b0;
      run(2);
      clear_stats();

      // Single set, held high: one pulse after edge 8.
      set_req = 1'b1;
      run(30);
      check("single_s_first", s_first, 8);
      check("single_s_cnt", s_cnt, 1);
      check("single_r_cnt", r_cnt, 0);
      check("single_conflict_cnt", c_cnt, 0);

      // Falling debounced level must not produce an event.
      clear_stats();
      set_req = 1'b0;
      run(15);
      check("fall_no_s", s_cnt, 0);

      // Asynchronous reset in the middle of the s pulse.
      do_reset();
      set_req = 1'b1;
      run(8);
      check("midreset_s_before", int'(s), 1);
      #2;
      reset   = 1'b1;
      set_req = 1'b0;
      #1;
      check("midreset_s_async", int'(s), 0);
      run(2);
      reset = 1'b0;
      clear_stats();
      run(20);
      check("after_reset_s_cnt", s_cnt, 0);
      check("after_reset_r_cnt", r_cnt, 0);

      // Bounce: 3-cycle high glitch filtered, then a stable rise.
      do_reset();
      clr_req = 1'b1; run(3);
      clr_req = 1'b0; run(3);
      check("glitch_no_r", r_cnt, 0);
      clear_stats();
      clr_req = 1'b1;
      run(25);
      check("bounce_r_first", r_first, 8);
      check("bounce_r_cnt", r_cnt, 1);
      check("bounce_s_cnt", s_cnt, 0);

      // Queued: clr rises 2 cycles after set -> s at 8, r at 11.
      do_reset();
      set_req = 1'b1; run(2);
      clr_req = 1'b1; run(25);
      check("queued_s_first", s_first, 8);
      check("queued_r_first", r_first, 11);
      check("queued_s_cnt", s_cnt, 1);
      check("queued_r_cnt", r_cnt, 1);
      check("queued_overlap", overlap, 0);
      check("queued_conflict", c_cnt, 0);

      // Simultaneous requests.
      do_reset();
      set_req = 1'b1;
      clr_req = 1'b1;
      run(25);
      check("simul_conflict_first", c_first, 8);
      check("simul_conflict_cnt", c_cnt, 1);
      check("simul_r_cnt", r_cnt, 0);
      check("simul_overlap", overlap, 0);
`ifdef SR_CMD_SET_PRIORITY_EN
      check("simul_s_first", s_first, 8);
      check("simul_s_cnt", s_cnt, 1);
`else
      check("simul_s_cnt", s_cnt, 0);
`endif

      // Set event arriving during PULSE_R/GAP stays pending and is served once from IDLE.
      do_reset();
      clr_req = 1'b1; run(3);
      set_req = 1'b1; run(25);
      check("pend_r_first", r_first, 8);
      check("pend_s_first", s_first, 11);
      check("pend_s_cnt", s_cnt, 1);
      check("pend_r_cnt", r_cnt, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
